// File: rtl/hdb3_encoder.sv
// hdb3_encoder: converts a serial NRZ bit stream (one bit per clk) into HDB3
// line symbols using three registered stages.
//   stage 1 : zero-run tracking, every 4th consecutive zero becomes V
//   stage 2 : 4-deep code delay line, 000V becomes B00V when the count of
//             ones since the last V is even
//   stage 3 : AMI polarity; B alternates like a one, V repeats the last pulse
// Stage codes are exported for debug.
//
// Zero-run FSM (stage 1):
//   state | meaning
//   RUN0  | no zeros pending (last input was a one, or a V was just emitted)
//   RUN1  | one zero seen in the current run
//   RUN2  | two zeros seen in the current run
//   RUN3  | three zeros seen; the next zero is replaced by V
//
// Reset is synchronous and active high, despite the port name reset_n.
module hdb3_encoder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       datain,
  output logic [1:0] dataout_v,
  output logic [1:0] dataout_b,
  output logic [2:0] dataout
);

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_B    = 2'b10;
  localparam logic [1:0] CODE_V    = 2'b11;

  localparam logic [1:0] LINE_ZERO = 2'b00;
  localparam logic [1:0] LINE_POS  = 2'b01;
  localparam logic [1:0] LINE_NEG  = 2'b10;

  typedef enum logic [1:0] {
    RUN0 = 2'd0,
    RUN1 = 2'd1,
    RUN2 = 2'd2,
    RUN3 = 2'd3
  } run_state_t;

  run_state_t run_state;
  run_state_t run_next;
  logic [1:0] v_next;

  logic [1:0] s0;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] s3;
  logic [1:0] s3_next;
  logic       parity_odd;
  logic       parity_next;

  logic       last_pos;
  logic       last_next;
  logic [2:0] line_next;

  // Stage 1 next state: count zeros and substitute the fourth with V.
  always_comb begin
    run_next = run_state;
    v_next   = CODE_ZERO;
    if (datain) begin
      v_next   = CODE_ONE;
      run_next = RUN0;
    end else begin
      case (run_state)
        RUN0:    run_next = RUN1;
        RUN1:    run_next = RUN2;
        RUN2:    run_next = RUN3;
        RUN3: begin
          v_next   = CODE_V;
          run_next = RUN0;
        end
        default: run_next = RUN0;
      endcase
    end
  end

  // Stage 1 registers: zero-run state and the V-inserted code.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      run_state <= RUN0;
      dataout_v <= CODE_ZERO;
    end else begin
      run_state <= run_next;
      dataout_v <= v_next;
    end
  end

  // Stage 2 next state: when V is about to enter s0, s2 holds the first zero
  // of its group; rewrite it to B on its way into s3 if the ones count is even.
  always_comb begin
    s3_next     = s2;
    parity_next = parity_odd;
    if (dataout_v == CODE_V) begin
      if (!parity_odd) begin
        s3_next = CODE_B;
      end
      parity_next = 1'b0;
    end else if (dataout_v == CODE_ONE) begin
      parity_next = ~parity_odd;
    end
  end

  // Stage 2 registers: delay line and parity of ones since the last V.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      s0         <= CODE_ZERO;
      s1         <= CODE_ZERO;
      s2         <= CODE_ZERO;
      s3         <= CODE_ZERO;
      parity_odd <= 1'b0;
    end else begin
      s0         <= dataout_v;
      s1         <= s0;
      s2         <= s1;
      s3         <= s3_next;
      parity_odd <= parity_next;
    end
  end

  assign dataout_b = s3;

  // Stage 3 next state: ones and B alternate polarity, V repeats the last pulse.
  always_comb begin
    line_next = {1'b0, LINE_ZERO};
    last_next = last_pos;
    case (dataout_b)
      CODE_ONE: begin
        line_next = {1'b0, (last_pos ? LINE_NEG : LINE_POS)};
        last_next = ~last_pos;
      end
      CODE_B: begin
        line_next = {1'b1, (last_pos ? LINE_NEG : LINE_POS)};
        last_next = ~last_pos;
      end
      CODE_V: begin
        line_next = {1'b1, (last_pos ? LINE_POS : LINE_NEG)};
      end
      default: begin
        line_next = {1'b0, LINE_ZERO};
      end
    endcase
  end

  // Stage 3 registers: line symbol and last pulse polarity (negative after
  // reset so the first pulse goes out positive).
  always_ff @(posedge clk) begin
    if (reset_n) begin
      dataout  <= 3'b000;
      last_pos <= 1'b0;
    end else begin
      dataout  <= line_next;
      last_pos <= last_next;
    end
  end

endmodule

// File: tb/tb_hdb3_encoder.sv
// Directed and random checks for hdb3_encoder.
module tb_hdb3_encoder;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] O = 2'b01;
  localparam logic [1:0] B = 2'b10;
  localparam logic [1:0] V = 2'b11;

  localparam logic [2:0] LZ  = 3'b000;
  localparam logic [2:0] LP  = 3'b001;
  localparam logic [2:0] LN  = 3'b010;
  localparam logic [2:0] LPX = 3'b101;
  localparam logic [2:0] LNX = 3'b110;

  localparam bit         T1_D [18] = '{1,0,1,0,1,1,0,0,0,0,0,1,1,0,0,0,0,1};
  localparam logic [1:0] T1_V [18] = '{O,Z,O,Z,O,O,Z,Z,Z,V,Z,O,O,Z,Z,Z,V,O};
  localparam logic [1:0] T1_B [18] = '{O,Z,O,Z,O,O,B,Z,Z,V,Z,O,O,B,Z,Z,V,O};
  localparam logic [2:0] T1_L [18] = '{LP,LZ,LN,LZ,LP,LN,LPX,LZ,LZ,LPX,LZ,LN,LP,LNX,LZ,LZ,LNX,LP};

  localparam bit         T2_D [5] = '{1,0,0,0,0};
  localparam logic [1:0] T2_V [5] = '{O,Z,Z,Z,V};
  localparam logic [2:0] T2_L [5] = '{LP,LZ,LZ,LZ,LPX};

  localparam logic [1:0] T3_V [8] = '{Z,Z,Z,V,Z,Z,Z,V};
  localparam logic [1:0] T3_B [8] = '{B,Z,Z,V,B,Z,Z,V};
  localparam logic [2:0] T3_L [8] = '{LPX,LZ,LZ,LPX,LNX,LZ,LZ,LNX};

  localparam bit         T5_D [5] = '{0,0,0,0,1};
  localparam logic [1:0] T5_V [5] = '{Z,Z,Z,V,O};
  localparam logic [1:0] T5_B [5] = '{B,Z,Z,V,O};
  localparam logic [2:0] T5_L [5] = '{LPX,LZ,LZ,LPX,LN};

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       datain = 1'b0;
  logic [1:0] dataout_v;
  logic [1:0] dataout_b;
  logic [2:0] dataout;

  bit         stim  [64];
  logic [1:0] cap_v [64];
  logic [1:0] cap_b [64];
  logic [2:0] cap_l [64];

  int n_checks = 0;
  int n_fail   = 0;

  hdb3_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .datain    (datain),
    .dataout_v (dataout_v),
    .dataout_b (dataout_b),
    .dataout   (dataout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    datain  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
  endtask

  // Feeds stim[0..n-1] followed by zeros; capture i is taken after the edge
  // that sampled bit i.
  task automatic run_stim(input int n);
    for (int i = 0; i < n + 6; i++) begin
      datain = (i < n) ? stim[i] : 1'b0;
      @(posedge clk);
      #1;
      cap_v[i] = dataout_v;
      cap_b[i] = dataout_b;
      cap_l[i] = dataout;
    end
  endtask

  int  zrun, zviol, vviol, vsame_viol, alt_viol, flag_viol, v_count;
  bit  have_v, have_nonv, have_pulse, last_v_pos, last_nonv_pos, last_pulse_pos, pos;
  logic [1:0] prev_b;

  initial begin
    // reset state
    do_reset();
    check("reset_v", dataout_v, Z);
    check("reset_b", dataout_b, Z);
    check("reset_l", dataout, LZ);

    // mixed stream with two B substitutions
    for (int i = 0; i < 18; i++) stim[i] = T1_D[i];
    run_stim(18);
    for (int i = 0; i < 4; i++) check($sformatf("t1_fill_b%0d", i), cap_b[i], Z);
    for (int i = 0; i < 5; i++) check($sformatf("t1_fill_l%0d", i), cap_l[i], LZ);
    for (int i = 0; i < 18; i++) begin
      check($sformatf("t1_v%0d", i), cap_v[i], T1_V[i]);
      check($sformatf("t1_b%0d", i), cap_b[i + 4], T1_B[i]);
      check($sformatf("t1_l%0d", i), cap_l[i + 5], T1_L[i]);
    end

    // odd parity: V without B
    do_reset();
    for (int i = 0; i < 5; i++) stim[i] = T2_D[i];
    run_stim(5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_v%0d", i), cap_v[i], T2_V[i]);
      check($sformatf("t2_b%0d", i), cap_b[i + 4], T2_V[i]);
      check($sformatf("t2_l%0d", i), cap_l[i + 5], T2_L[i]);
    end

    // eight zeros: B00V B00V with alternating polarity
    do_reset();
    for (int i = 0; i < 8; i++) stim[i] = 1'b0;
    run_stim(8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_v%0d", i), cap_v[i], T3_V[i]);
      check($sformatf("t3_b%0d", i), cap_b[i + 4], T3_B[i]);
      check($sformatf("t3_l%0d", i), cap_l[i + 5], T3_L[i]);
    end

    // latency of a single one
    do_reset();
    stim[0] = 1'b1;
    run_stim(1);
    check("lat_v0", cap_v[0], O);
    for (int i = 0; i < 4; i++) check($sformatf("lat_b%0d", i), cap_b[i], Z);
    check("lat_b4", cap_b[4], O);
    for (int i = 0; i < 5; i++) check($sformatf("lat_l%0d", i), cap_l[i], LZ);
    check("lat_l5", cap_l[5], LP);

    // reset in the middle of a zero run
    do_reset();
    stim[0] = 1'b1; stim[1] = 1'b0; stim[2] = 1'b0;
    run_stim(3 - 6 + 6 > 0 ? 3 : 3);
    do_reset();
    check("mid_reset_v", dataout_v, Z);
    check("mid_reset_b", dataout_b, Z);
    check("mid_reset_l", dataout, LZ);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      datain = (i == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    datain  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    check("mid2_reset_v", dataout_v, Z);
    check("mid2_reset_l", dataout, LZ);
    for (int i = 0; i < 5; i++) stim[i] = T5_D[i];
    run_stim(5);
    for (int i = 0; i < 4; i++) check($sformatf("mid_flush_b%0d", i), cap_b[i], Z);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mid_v%0d", i), cap_v[i], T5_V[i]);
      check($sformatf("mid_b%0d", i), cap_b[i + 4], T5_B[i]);
      check($sformatf("mid_l%0d", i), cap_l[i + 5], T5_L[i]);
    end

    // long random stream: line invariants
    do_reset();
    zrun = 0; zviol = 0; vviol = 0; vsame_viol = 0; alt_viol = 0; flag_viol = 0; v_count = 0;
    have_v = 0; have_nonv = 0; have_pulse = 0;
    last_v_pos = 0; last_nonv_pos = 0; last_pulse_pos = 0;
    prev_b = Z;
    for (int i = 0; i < 12000; i++) begin
      datain = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (i >= 5) begin
        if (dataout[2] !== ((prev_b == B) || (prev_b == V))) flag_viol++;
        if (dataout[1:0] == 2'b00) begin
          zrun++;
          if (zrun > 3) zviol++;
        end else begin
          zrun = 0;
          pos = (dataout[1:0] == 2'b01);
          if (prev_b == V) begin
            v_count++;
            if (have_v && (pos == last_v_pos)) vviol++;
            if (have_pulse && (pos != last_pulse_pos)) vsame_viol++;
            last_v_pos = pos;
            have_v = 1;
          end else begin
            if (have_nonv && (pos == last_nonv_pos)) alt_viol++;
            last_nonv_pos = pos;
            have_nonv = 1;
          end
          last_pulse_pos = pos;
          have_pulse = 1;
        end
      end
      prev_b = dataout_b;
    end
    check("rnd_zero_run_gt3", zviol, 0);
    check("rnd_v_same_pol", vviol, 0);
    check("rnd_v_not_repeat", vsame_viol, 0);
    check("rnd_pulse_alt", alt_viol, 0);
    check("rnd_bv_flag", flag_viol, 0);
    check("rnd_v_seen", (v_count > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
